// File: rtl/alu_core.sv
// Registered ALU with status flags: one-cycle latency and an async active-low reset.
// Define ALU_MULT_EN to build the multiplier for opcode 1000; without it that opcode yields 0.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Control,
  output logic [WIDTH-1:0] Answer,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Negative
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] answer_d, answer_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_q, negative_q;

  assign shamt = B[SW-1:0];

  always_comb begin
    ext        = '0;
    answer_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (Control)
      4'b0000: begin
        ext        = {1'b0, A} + {1'b0, B};
        answer_d   = ext[WIDTH-1:0];
        carry_d    = ext[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (answer_d[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        // The extra top bit of the widened difference is the borrow.
        ext        = {1'b0, A} - {1'b0, B};
        answer_d   = ext[WIDTH-1:0];
        carry_d    = ext[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (answer_d[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: answer_d = A & B;
      4'b0011: answer_d = A | B;
      4'b0100: answer_d = A ^ B;
      4'b0101: answer_d = ~A;
      4'b0110: answer_d = A << shamt;
      4'b0111: answer_d = A >> shamt;
      4'b1000: begin
`ifdef ALU_MULT_EN
        answer_d = A * B;
`else
        answer_d = '0;
`endif
      end
      4'b1001: answer_d = $signed(A) >>> shamt;
      4'b1010: begin
        ext        = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        answer_d   = ext[WIDTH-1:0];
        carry_d    = ext[WIDTH];
        overflow_d = !A[WIDTH-1] && answer_d[WIDTH-1];
      end
      4'b1011: begin
        ext        = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
        answer_d   = ext[WIDTH-1:0];
        carry_d    = ext[WIDTH];
        overflow_d = A[WIDTH-1] && !answer_d[WIDTH-1];
      end
      4'b1100: answer_d = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1101: answer_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1110: answer_d = ~(A & B);
      4'b1111: answer_d = B;
      default: answer_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      answer_q   <= answer_d;
      zero_q     <= (answer_d == '0);
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= answer_d[WIDTH-1];
    end
  end

  assign Answer   = answer_q;
  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign Overflow = overflow_q;
  assign Negative = negative_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, reset sequences, and
// randomized stimulus against an arithmetic reference model.
module tb_alu_core;

  localparam int W = 16;
  localparam longint M = longint'(1) << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [3:0]    Control = '0;
  logic [W-1:0]  Answer;
  logic          Zero, Carry, Overflow, Negative;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] ans;
    logic         z, c, v, n;
  } vec_t;

  vec_t tbl[$];

  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Control(Control),
    .Answer(Answer), .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .Negative(Negative)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] observed();
    return {Answer, Zero, Carry, Overflow, Negative};
  endfunction

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ans=%h zcvn=%b, expected ans=%h zcvn=%b",
               name, act[W+3:4], act[3:0], exp[W+3:4], exp[3:0]);
    end
  endtask

  function automatic longint to_signed(input longint x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Reference model: plain integer arithmetic on unbounded values, then reduced mod 2^W.
  function automatic logic [W+3:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                         input logic [3:0] op);
    longint a  = longint'(ai);
    longint b  = longint'(bi);
    longint sa = to_signed(a);
    longint sb = to_signed(b);
    longint p  = longint'(1) << (b % W);
    longint r  = 0;
    longint sr = 0;
    logic   c  = 1'b0;
    logic   v  = 1'b0;
    logic [W-1:0] ans;
    case (op)
      4'd0:  begin r = a + b; c = (r >= M); sr = sa + sb; v = (sr < -M/2) || (sr >= M/2); end
      4'd1:  begin r = a - b; c = (a < b);  sr = sa - sb; v = (sr < -M/2) || (sr >= M/2); end
      4'd2:  r = longint'(ai & bi);
      4'd3:  r = longint'(ai | bi);
      4'd4:  r = longint'(ai ^ bi);
      4'd5:  r = (M - 1) - a;
      4'd6:  r = a * p;
      4'd7:  r = a / p;
`ifdef ALU_MULT_EN
      4'd8:  r = a * b;
`else
      4'd8:  r = 0;
`endif
      4'd9:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd10: begin r = a + 1; c = (r >= M); sr = sa + 1; v = (sr >= M/2); end
      4'd11: begin r = a - 1; c = (a == 0); sr = sa - 1; v = (sr < -M/2); end
      4'd12: r = (a < b) ? 1 : 0;
      4'd13: r = (sa < sb) ? 1 : 0;
      4'd14: r = (M - 1) - longint'(ai & bi);
      default: r = b;
    endcase
    r   = ((r % M) + M) % M;
    ans = r[W-1:0];
    return {ans, (r == 0), c, v, (r >= M / 2)};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    @(negedge clk);
    A = a; B = b; Control = op;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    logic [W+3:0] exp_q;
    bit           have_exp;

    tbl.push_back('{16'd10,   16'd20,   4'b0100, 16'h001E, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef ALU_MULT_EN
    tbl.push_back('{16'd30,   16'd9,    4'b1000, 16'h010E, 1'b0, 1'b0, 1'b0, 1'b0});
`else
    tbl.push_back('{16'd30,   16'd9,    4'b1000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
    tbl.push_back('{16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 4'b0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 4'b1101, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 4'b1100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h1234, 16'h0000, 4'b0110, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h8001, 16'h0014, 4'b1001, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{16'h8001, 16'h0004, 4'b0111, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h0000, 16'h1234, 4'b1011, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{16'h7FFF, 16'h0000, 4'b1010, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{16'h00F0, 16'h0000, 4'b0101, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{16'h0001, 16'h000F, 4'b0110, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{16'h1234, 16'h5678, 4'b1111, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 4'b1110, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{16'hFFFF, 16'h0000, 4'b1010, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset state before any clock edge, then inputs applied during reset must not load.
    #3;
    check("reset_initial", observed(), '0);
    A = 16'hFFFF; B = 16'h0001; Control = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_holds_inputs", observed(), '0);

    // First edge after release loads the normal result.
    drive(16'd10, 16'd20, 4'b0100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset", observed(), {16'h001E, 4'b0000});

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].op);
      @(posedge clk); #1;
      check($sformatf("vec%0d_op%b", i, tbl[i].op), observed(),
            {tbl[i].ans, tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].n});
    end

    // Async reset mid-operation with a nonzero Answer.
    drive(16'h1234, 16'hBEEF, 4'b1111);
    @(posedge clk); #1;
    check("pre_async_reset", observed(), {16'hBEEF, 4'b0001});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_immediate", observed(), '0);
    @(posedge clk); #1;
    check("async_reset_held", observed(), '0);
    drive(16'h8000, 16'h0001, 4'b0001);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_async_release", observed(), {16'h7FFF, 4'b0010});

    // Randomized back-to-back stream, one new vector per cycle.
    have_exp = 1'b0;
    exp_q    = '0;
    for (int k = 0; k < 400; k++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: ra = 16'h8000;
        2: ra = 16'h7FFF;
        3: rb = 16'h0000;
        default: ;
      endcase
      @(negedge clk);
      if (have_exp) check($sformatf("rand%0d", k), observed(), exp_q);
      A = ra; B = rb; Control = rop;
      exp_q    = model(ra, rb, rop);
      have_exp = 1'b1;
    end
    @(negedge clk);
    check("rand_last", observed(), exp_q);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter WIDTH, default 16, data width of A, B and Answer; shift amount uses the low log2(WIDTH) bits of B.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 A  input  WIDTH  first operand.
REQ-005 B  input  WIDTH  second operand or shift amount.
REQ-006 Control  input  4  opcode.
REQ-007 Answer  output  WIDTH  registered result.
REQ-008 Zero, Carry, Overflow, Negative  output  1 each  registered status flags.

Function
REQ-009 Answer and the flags SHALL be registered: on each rising clk edge they take the result of the A, B and Control values present before that edge (one-cycle latency, no enable, no handshake).
REQ-010 Opcode map:
- 0000 A+B
- 0001 A-B
- 0010 A&B
- 0011 A|B
- 0100 A^B
- 0101 ~A
- 0110 A << B[3:0]
- 0111 A >> B[3:0], logical
- 1000 low WIDTH bits of A*B (see REQ-019)
- 1001 A >>> B[3:0], arithmetic
- 1010 A+1
- 1011 A-1
- 1100 unsigned A<B, result 1 or 0
- 1101 signed A<B, result 1 or 0
- 1110 ~(A&B)
- 1111 B
REQ-011 All arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-012 Zero SHALL be 1 when the new Answer equals 0.
REQ-013 Negative SHALL be the MSB of the new Answer.
REQ-014 Carry SHALL be the carry-out for 0000 and 1010, and the borrow (A<B unsigned, or A=0 for 1011) for 0001 and 1011; it SHALL be 0 for all other opcodes.
REQ-015 Overflow SHALL be the two's-complement signed overflow for 0000, 0001, 1010 and 1011; it SHALL be 0 for all other opcodes.
REQ-016 A shift amount of 0 SHALL return A unchanged; shifts SHALL fill with 0, except 1001, which fills with A's MSB.

Reset
REQ-017 While rst_n=0, Answer, Zero, Carry, Overflow and Negative SHALL be 0 immediately, independent of clk.
REQ-018 After rst_n rises, the first rising clk edge SHALL load the normal result; inputs applied during reset SHALL have no effect.

Configuration
REQ-019 Macro ALU_MULT_EN:
- When defined, opcode 1000 SHALL produce the low WIDTH bits of the unsigned product A*B.
- When undefined, no multiplier SHALL be synthesized, and opcode 1000 SHALL produce Answer=0 with Zero=1 and all other flags 0.

Verification
REQ-020 rst_n=0 mid-operation with Answer nonzero -> Answer=0 and all flags 0 immediately, without waiting for a clock edge.
REQ-021 A=10, B=20, Control=0100 -> after the next rising edge, Answer=30 (0x001E), Zero=0, Carry=0.
REQ-022 A=30, B=9, Control=1000 -> Answer=270 (0x010E) with ALU_MULT_EN defined; Answer=0 and Zero=1 without it.
REQ-023 A=0xFFFF, B=1, Control=0000 -> Answer=0, Zero=1, Carry=1, Overflow=0.
REQ-024 A=0x8000, B=1, Control=0001 -> Answer=0x7FFF, Overflow=1, Carry=0, Negative=0.
REQ-025 A=0xFFFF, B=1: Control=1101 -> Answer=1; Control=1100 -> Answer=0.
